// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and helpers for the memory access arbiter.
//   - state_e    : arbiter FSM states (encoding is visible on the mstate port)
//   - ACC_NONE   : accmodule value when nobody owns the port
//   - onehot2idx : converts a one-hot vector (up to 32 bits) to its bit index
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    PREEMPT = 2'b10
  } state_e;

  localparam int unsigned ACC_NONE = 32'd0;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_rr_pick
//   Combinational round-robin picker over requesters 1..N-1 (bit 0 is the
//   priority requester and is never picked here). The search starts at the
//   index following ptr and wraps within 1..N-1.
// Ports:
//   req   in  N    request vector (bit 0 ignored)
//   ptr   in  IW   index of the last round-robin winner
//   gnt   out N    one-hot winner, all-zero when none
//   valid out 1    a winner exists
// ----------------------------------------------------------------------------
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  // Walk the ring 1..N-1 starting after ptr; the first requester seen wins.
  always_comb begin
    int   base_v;
    int   cand_v;
    logic found_v;
    gnt     = '0;
    found_v = 1'b0;
    cand_v  = 0;
    // Ring position of ptr (0..N-2); a pointer of 0 behaves like N-1.
    base_v  = (int'(ptr) == 0) ? (N - 2) : (int'(ptr) - 1);
    for (int k = 1; k < N; k++) begin
      cand_v = ((base_v + k) % (N - 1)) + 1;
      if (!found_v && req[cand_v]) begin
        gnt[cand_v] = 1'b1;
        found_v     = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
    valid = found_v;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// ----------------------------------------------------------------------------
// mem_access_arbiter
//   Arbitrates one shared memory port among NUM_REQ requesters. Requester 0
//   has top priority and preempts any other owner; other owners are limited
//   to MAX_HOLD consecutive BUSY cycles; ties among 1..NUM_REQ-1 rotate.
//   A preempted owner is resumed (even with its request low) once
//   requester 0 releases.
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous active-low reset
//   req        in   NUM_REQ    request levels
//   done       in   NUM_REQ    release strobes, only the owner's is honoured
//   gnt        out  NUM_REQ    one-hot grant (drives the port mux)
//   mstate     out  2          00 IDLE, 01 BUSY, 10 PREEMPT
//   accmodule  out  AW         owner index+1 while BUSY, else 0
//   preempt    out  1          pulse during the PREEMPT cycle
//   timeout    out  1          pulse in the cycle after a forced release
//   grant_cnt  out  NUM_REQ*CNT_W  per-requester saturating grant count
//   timeout_cnt out CNT_W      saturating timeout count
// Configuration:
//   MEM_ARB_STATS_EN  when defined, adds grant_cnt/timeout_cnt and counters.
// ----------------------------------------------------------------------------
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 2,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [1:0]                   mstate,
  output logic [$clog2(NUM_REQ+1)-1:0] accmodule,
  output logic                         preempt,
  output logic                         timeout
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]     grant_cnt,
  output logic [CNT_W-1:0]             timeout_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(NUM_REQ + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);

  if (NUM_REQ < 2 || MAX_HOLD < 1 || CNT_W < 1) begin : g_param_check
    $error("mem_access_arbiter: illegal parameter set");
  end

  state_e             state_r, state_n;
  logic [IW-1:0]      owner_r, owner_n;
  logic [IW-1:0]      resume_idx_r, resume_idx_n;
  logic               resume_vld_r, resume_vld_n;
  logic [IW-1:0]      rr_ptr_r, rr_ptr_n;
  logic [HW-1:0]      hold_cnt_r, hold_cnt_n;
  logic [NUM_REQ-1:0] mask_r, mask_n;
  logic [NUM_REQ-1:0] gnt_r, gnt_n;
  logic [AW-1:0]      acc_r, acc_n;
  logic               preempt_r, preempt_n;
  logic               timeout_r, timeout_n;

  logic [NUM_REQ-1:0] cand_s;
  logic [NUM_REQ-1:0] rr_gnt_s;
  logic               rr_vld_s;
  logic [IW-1:0]      rr_idx_s;
  logic               grant_s;
  logic [IW-1:0]      grant_idx_s;

  // A requester that just timed out sits out exactly one arbitration.
  assign cand_s = req & ~mask_r;

  mem_arb_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (cand_s),
    .ptr   (rr_ptr_r),
    .gnt   (rr_gnt_s),
    .valid (rr_vld_s)
  );

  assign rr_idx_s = IW'(onehot2idx(32'(rr_gnt_s)));

  // Next-state, grant selection and next registered outputs.
  always_comb begin
    state_n      = state_r;
    owner_n      = owner_r;
    resume_idx_n = resume_idx_r;
    resume_vld_n = resume_vld_r;
    rr_ptr_n     = rr_ptr_r;
    hold_cnt_n   = hold_cnt_r;
    mask_n       = '0;
    gnt_n        = gnt_r;
    acc_n        = acc_r;
    preempt_n    = 1'b0;
    timeout_n    = 1'b0;
    grant_s      = 1'b0;
    grant_idx_s  = '0;

    case (state_r)
      IDLE: begin
        if (cand_s[0]) begin
          grant_s     = 1'b1;
          grant_idx_s = '0;
        end else if (resume_vld_r) begin
          // Resume wins regardless of its request level.
          grant_s      = 1'b1;
          grant_idx_s  = resume_idx_r;
          resume_vld_n = 1'b0;
        end else if (rr_vld_s) begin
          grant_s     = 1'b1;
          grant_idx_s = rr_idx_s;
          rr_ptr_n    = rr_idx_s;
        end else begin
          grant_s = 1'b0;
        end
      end

      BUSY: begin
        // Release precedence: done, then hold budget, then preemption.
        if (done[owner_r]) begin
          state_n    = IDLE;
          gnt_n      = '0;
          acc_n      = AW'(ACC_NONE);
          hold_cnt_n = '0;
        end else if (owner_r != '0 && hold_cnt_r == HW'(MAX_HOLD)) begin
          state_n         = IDLE;
          gnt_n           = '0;
          acc_n           = AW'(ACC_NONE);
          hold_cnt_n      = '0;
          timeout_n       = 1'b1;
          mask_n[owner_r] = 1'b1;
        end else if (owner_r != '0 && req[0]) begin
          state_n      = PREEMPT;
          gnt_n        = '0;
          acc_n        = AW'(ACC_NONE);
          hold_cnt_n   = '0;
          preempt_n    = 1'b1;
          resume_vld_n = 1'b1;
          resume_idx_n = owner_r;
        end else if (hold_cnt_r < HW'(MAX_HOLD)) begin
          hold_cnt_n = hold_cnt_r + HW'(1);
        end else begin
          hold_cnt_n = hold_cnt_r;
        end
      end

      PREEMPT: begin
        // Requester 0 takes the port unconditionally after the bubble.
        grant_s     = 1'b1;
        grant_idx_s = '0;
      end

      default: begin
        state_n    = IDLE;
        gnt_n      = '0;
        acc_n      = AW'(ACC_NONE);
        hold_cnt_n = '0;
      end
    endcase

    if (grant_s) begin
      state_n    = BUSY;
      owner_n    = grant_idx_s;
      hold_cnt_n = HW'(1);
      gnt_n      = NUM_REQ'(1) << grant_idx_s;
      acc_n      = AW'(grant_idx_s) + AW'(1);
    end else begin
      owner_n = owner_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      owner_r      <= '0;
      resume_idx_r <= '0;
      resume_vld_r <= 1'b0;
      rr_ptr_r     <= IW'(NUM_REQ - 1);
      hold_cnt_r   <= '0;
      mask_r       <= '0;
      gnt_r        <= '0;
      acc_r        <= AW'(ACC_NONE);
      preempt_r    <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      owner_r      <= owner_n;
      resume_idx_r <= resume_idx_n;
      resume_vld_r <= resume_vld_n;
      rr_ptr_r     <= rr_ptr_n;
      hold_cnt_r   <= hold_cnt_n;
      mask_r       <= mask_n;
      gnt_r        <= gnt_n;
      acc_r        <= acc_n;
      preempt_r    <= preempt_n;
      timeout_r    <= timeout_n;
    end
  end

  assign gnt       = gnt_r;
  assign mstate    = state_r;
  assign accmodule = acc_r;
  assign preempt   = preempt_r;
  assign timeout   = timeout_r;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_r [NUM_REQ];
  logic [CNT_W-1:0] timeout_cnt_r;

  // Saturating grant and timeout statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_r[i] <= '0;
      end
      timeout_cnt_r <= '0;
    end else begin
      if (grant_s && grant_cnt_r[grant_idx_s] != '1) begin
        grant_cnt_r[grant_idx_s] <= grant_cnt_r[grant_idx_s] + CNT_W'(1);
      end
      if (timeout_n && timeout_cnt_r != '1) begin
        timeout_cnt_r <= timeout_cnt_r + CNT_W'(1);
      end
    end
  end

  // Flatten per-requester counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = grant_cnt_r[i];
    end
  end

  assign timeout_cnt = timeout_cnt_r;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_access_arbiter
//   Table of directed vectors for the documented scenarios, followed by
//   random traffic compared against a behavioural model of the arbiter.
// ----------------------------------------------------------------------------
module tb_mem_access_arbiter;

  localparam int N  = 3;
  localparam int MH = 2;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic [1:0] mstate;
  logic [1:0] accmodule;
  logic       preempt;
  logic       timeout;
`ifdef MEM_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt;
  logic [CW-1:0]   timeout_cnt;
`endif

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .mstate    (mstate),
    .accmodule (accmodule),
    .preempt   (preempt),
    .timeout   (timeout)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit       rst;
    bit [2:0] rq;
    bit [2:0] dn;
    bit [2:0] eg;
    bit [1:0] ems;
    bit [1:0] eacc;
    bit       epre;
    bit       eto;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit [2:0] rq, input bit [2:0] dn,
                     input bit [2:0] eg, input bit [1:0] ems, input bit [1:0] eacc,
                     input bit epre, input bit eto);
    vec_t v;
    v = '{rst, rq, dn, eg, ems, eacc, epre, eto};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input bit [2:0] eg, input bit [1:0] ems,
                       input bit [1:0] eacc, input bit epre, input bit eto);
    vectors++;
    if (gnt !== eg || mstate !== ems || accmodule !== eacc || preempt !== epre || timeout !== eto) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b mstate=%b acc=%0d pre=%b to=%b, want gnt=%b mstate=%b acc=%0d pre=%b to=%b",
               name, gnt, mstate, accmodule, preempt, timeout, eg, ems, eacc, epre, eto);
    end
  endtask

  task automatic check_stats_zero(input string name);
`ifdef MEM_ARB_STATS_EN
    vectors++;
    if (grant_cnt !== '0 || timeout_cnt !== '0) begin
      miscompares++;
      $display("FAIL %s stats: got grant_cnt=%h timeout_cnt=%h, want 0", name, grant_cnt, timeout_cnt);
    end
`else
    vectors = vectors + 0;
`endif
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 idle, 1 busy, 2 preempt bubble. Indices are plain ints, -1 = none.
  int m_phase, m_owner, m_hold, m_resume, m_last, m_mask;
  bit m_to;

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_hold = 0; m_resume = -1; m_last = N - 1; m_mask = -1; m_to = 1'b0;
  endtask

  task automatic model_step(input bit [2:0] r, input bit [2:0] d);
    int blocked;
    int win;
    blocked = m_mask;
    m_mask  = -1;
    m_to    = 1'b0;
    win     = -1;
    case (m_phase)
      0: begin
        if (r[0]) win = 0;
        else if (m_resume >= 0) begin
          win = m_resume;
          m_resume = -1;
        end else begin
          for (int k = 1; k < N; k++) begin
            int i;
            i = ((m_last - 1 + k) % (N - 1)) + 1;
            if (win < 0 && r[i] && i != blocked) begin
              win = i;
              m_last = i;
            end
          end
        end
        if (win >= 0) begin
          m_phase = 1; m_owner = win; m_hold = 1;
        end
      end
      1: begin
        if (d[m_owner]) begin
          m_phase = 0; m_owner = -1; m_hold = 0;
        end else if (m_owner != 0 && m_hold >= MH) begin
          m_mask = m_owner; m_to = 1'b1;
          m_phase = 0; m_owner = -1; m_hold = 0;
        end else if (m_owner != 0 && r[0]) begin
          m_resume = m_owner;
          m_phase = 2; m_owner = -1; m_hold = 0;
        end else if (m_hold < MH) begin
          m_hold++;
        end
      end
      default: begin
        m_phase = 1; m_owner = 0; m_hold = 1;
      end
    endcase
  endtask

  task automatic check_model(input string name);
    bit [2:0] eg;
    bit [1:0] eacc;
    eg   = (m_phase == 1) ? 3'(1 << m_owner) : 3'b000;
    eacc = (m_phase == 1) ? 2'(m_owner + 1) : 2'd0;
    check(name, eg, 2'(m_phase), eacc, (m_phase == 2), m_to);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    string nm;
    // Reset applies without any clock edge.
    reset = 1'b0; req = 3'b111; done = 3'b000;
    #3;
    check("reset_immediate", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);
    check_stats_zero("reset_immediate");
    @(posedge clk); #1;
    check("reset_held", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);
    reset = 1'b1; req = 3'b000;

    // rst, req, done, gnt, mstate, acc, preempt, timeout
    add(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    // preempt and resume
    add(0, 3'b010, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    add(0, 3'b001, 3'b000, 3'b000, 2'd2, 2'd0, 1, 0);
    add(0, 3'b001, 3'b000, 3'b001, 2'd1, 2'd1, 0, 0);
    add(0, 3'b000, 3'b001, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b000, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    add(0, 3'b000, 3'b010, 3'b000, 2'd0, 2'd0, 0, 0);
    // hold budget with masked re-request
    add(0, 3'b100, 3'b000, 3'b100, 2'd1, 2'd3, 0, 0);
    add(0, 3'b100, 3'b000, 3'b100, 2'd1, 2'd3, 0, 0);
    add(0, 3'b100, 3'b000, 3'b000, 2'd0, 2'd0, 0, 1);
    add(0, 3'b100, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b100, 3'b000, 3'b100, 2'd1, 2'd3, 0, 0);
    // non-M1 request does not preempt
    add(0, 3'b010, 3'b000, 3'b100, 2'd1, 2'd3, 0, 0);
    add(0, 3'b010, 3'b000, 3'b000, 2'd0, 2'd0, 0, 1);
    add(0, 3'b010, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    add(0, 3'b000, 3'b010, 3'b000, 2'd0, 2'd0, 0, 0);
    // round-robin after reset
    add(1, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b110, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    add(0, 3'b000, 3'b010, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b110, 3'b000, 3'b100, 2'd1, 2'd3, 0, 0);
    add(0, 3'b000, 3'b100, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b110, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    // done beats preempt; M1 exempt from budget; non-owner done ignored
    add(0, 3'b001, 3'b010, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b001, 3'b000, 3'b001, 2'd1, 2'd1, 0, 0);
    add(0, 3'b001, 3'b000, 3'b001, 2'd1, 2'd1, 0, 0);
    add(0, 3'b001, 3'b000, 3'b001, 2'd1, 2'd1, 0, 0);
    add(0, 3'b001, 3'b000, 3'b001, 2'd1, 2'd1, 0, 0);
    add(0, 3'b000, 3'b100, 3'b001, 2'd1, 2'd1, 0, 0);
    add(0, 3'b000, 3'b001, 3'b000, 2'd0, 2'd0, 0, 0);
    // async reset mid-BUSY
    add(0, 3'b010, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    add(1, 3'b010, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    // reset drops a pending resume
    add(0, 3'b010, 3'b000, 3'b010, 2'd1, 2'd2, 0, 0);
    add(0, 3'b001, 3'b000, 3'b000, 2'd2, 2'd0, 1, 0);
    add(1, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);
    add(0, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 0, 0);

    for (int t = 0; t < tbl.size(); t++) begin
      req  = tbl[t].rq;
      done = tbl[t].dn;
      nm   = $sformatf("tbl[%0d]", t);
      if (tbl[t].rst) begin
        reset = 1'b0;
        #2;
        check(nm, tbl[t].eg, tbl[t].ems, tbl[t].eacc, tbl[t].epre, tbl[t].eto);
        check_stats_zero(nm);
        @(posedge clk); #1;
        reset = 1'b1;
      end else begin
        @(posedge clk); #1;
        check(nm, tbl[t].eg, tbl[t].ems, tbl[t].eacc, tbl[t].epre, tbl[t].eto);
      end
    end

    // Random traffic against the model, with occasional async resets.
    reset = 1'b0; req = 3'b000; done = 3'b000;
    #2;
    model_reset();
    check_model("rand_reset0");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      req  = {1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0)};
      done = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b0;
        #2;
        model_reset();
        check_model($sformatf("rand_rst[%0d]", c));
        @(posedge clk); #1;
        reset = 1'b1;
      end else begin
        @(posedge clk);
        model_step(req, done);
        #1;
        check_model($sformatf("rand[%0d]", c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
